// File: rtl/exampif_req_packer.sv
// Packs the ExampIf request byte stream into words and queues them behind a valid/ready port.
// Optional idle flush of partial words is enabled by defining EXAMPIF_PACK_FLUSH_EN.
module exampif_req_packer #(
   parameter int BYTES_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int FLUSH_CYCLES   = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                req_val,
   input  logic [7:0]                          req_dat,
   output logic                                out_val,
   input  logic                                out_rdy,
   output logic [8*BYTES_PER_WORD-1:0]         out_dat,
   output logic [$clog2(BYTES_PER_WORD):0]     out_nbytes,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
   output logic                                ovfl,
   input  logic                                ovfl_clr
);

   localparam int WW  = 8 * BYTES_PER_WORD;
   localparam int NBW = $clog2(BYTES_PER_WORD) + 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    PTR_ONE = (AW + 1)'(1);
   localparam logic [AW:0]    DEPTH_L = (AW + 1)'(FIFO_DEPTH);
   localparam logic [NBW-1:0] NB_FULL = NBW'(BYTES_PER_WORD);
   localparam logic [NBW-1:0] CNT_LAST = NBW'(BYTES_PER_WORD - 1);

   logic [WW-1:0]  asm_q, asm_d, asm_ins;
   logic [NBW-1:0] cnt_q, cnt_d;
   logic           push;
   logic [WW-1:0]  push_dat;
   logic [NBW-1:0] push_nb;

   logic [WW-1:0]  mem_q [FIFO_DEPTH];
   logic [NBW-1:0] nb_q  [FIFO_DEPTH];
   logic [AW:0]    wptr_q, rptr_q, level;
   logic [WW-1:0]  hold_dat_q;
   logic [NBW-1:0] hold_nb_q;
   logic           ovfl_q;
   logic           empty, full, pop, wr_en, ovfl_set;

   assign level    = wptr_q - rptr_q;
   assign empty    = (level == '0);
   assign full     = (level == DEPTH_L);
   assign pop      = !empty && out_rdy;
   assign wr_en    = push && (!full || pop);
   assign ovfl_set = push && full && !pop;

   always_comb begin
      asm_ins = asm_q;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (cnt_q == NBW'(i)) asm_ins[8*i +: 8] = req_dat;
      end
   end

`ifdef EXAMPIF_PACK_FLUSH_EN
   localparam int TW = $clog2(FLUSH_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          flush;

   // The expiry cycle is the FLUSH_CYCLES-th consecutive idle cycle; a byte on it wins.
   always_comb begin
      timer_d = timer_q;
      flush   = 1'b0;
      if (req_val || cnt_q == '0) begin
         timer_d = '0;
      end else if (timer_q == TW'(FLUSH_CYCLES - 1)) begin
         timer_d = '0;
         flush   = 1'b1;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end
`endif

   // Unused lanes above cnt are always zero because the assembly register clears on every push.
   always_comb begin
      push     = 1'b0;
      push_dat = asm_ins;
      push_nb  = NB_FULL;
      cnt_d    = cnt_q;
      asm_d    = asm_q;
      if (req_val) begin
         if (cnt_q == CNT_LAST) begin
            push  = 1'b1;
            cnt_d = '0;
            asm_d = '0;
         end else begin
            cnt_d = cnt_q + NBW'(1);
            asm_d = asm_ins;
         end
      end
`ifdef EXAMPIF_PACK_FLUSH_EN
      else if (flush) begin
         push     = 1'b1;
         push_dat = asm_q;
         push_nb  = cnt_q;
         cnt_d    = '0;
         asm_d    = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q      <= '0;
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         hold_dat_q <= '0;
         hold_nb_q  <= '0;
         ovfl_q     <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
            nb_q[i]  <= '0;
         end
      end else begin
         asm_q <= asm_d;
         cnt_q <= cnt_d;
         if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= push_dat;
            nb_q[wptr_q[AW-1:0]]  <= push_nb;
            wptr_q                <= wptr_q + PTR_ONE;
         end
         // The popped head is captured so outputs keep their last value once the FIFO empties.
         if (pop) begin
            hold_dat_q <= mem_q[rptr_q[AW-1:0]];
            hold_nb_q  <= nb_q[rptr_q[AW-1:0]];
            rptr_q     <= rptr_q + PTR_ONE;
         end
         if (ovfl_set)      ovfl_q <= 1'b1;
         else if (ovfl_clr) ovfl_q <= 1'b0;
      end
   end

   assign out_val    = !empty;
   assign out_dat    = empty ? hold_dat_q : mem_q[rptr_q[AW-1:0]];
   assign out_nbytes = empty ? hold_nb_q  : nb_q[rptr_q[AW-1:0]];
   assign fifo_level = level;
   assign ovfl       = ovfl_q;

endmodule

// File: doc/exampif_req_packer.md
Name: exampif_req_packer

Overview:
- Downstream consumer of the ExampIf request stream.
- Samples req_val/req_dat every clk edge, with the same timing the interface's monitor clocking block uses.
- Packs consecutive bytes into BYTES_PER_WORD-wide words and buffers them in a small FIFO.
- Presents words on a valid/ready output toward the request-processing logic.
- The input side has no backpressure; loss is reported through a sticky overflow flag.

Parameters:
- BYTES_PER_WORD, 4, bytes packed per output word (2..8).
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2).
- FLUSH_CYCLES, 16, idle cycles before a partial word is flushed (used only with the optional feature; ≥1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_val  input  1  request byte valid (ExampIf req_val).
- req_dat  input  8  request byte (ExampIf req_dat).
- out_val  output  1  FIFO head word valid.
- out_rdy  input  1  consumer accepts head word when out_val & out_rdy.
- out_dat  output  8*BYTES_PER_WORD  packed word; first byte received in bits [7:0].
- out_nbytes  output  $clog2(BYTES_PER_WORD)+1  count of valid bytes in out_dat.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovfl  output  1  sticky: a word was dropped.
- ovfl_clr  input  1  clears ovfl.

Behaviour:
- Reset (async assert, sync deassert by user):
  - out_val=0, out_dat=0, out_nbytes=0, fifo_level=0, ovfl=0.
  - Byte counter=0; assembly register=0; flush timer=0.
  - Reset mid-word or mid-FIFO discards all contents.
- Assembly:
  - Each cycle with req_val=1, req_dat is written to lane cnt (bits [8*cnt+7:8*cnt]) and cnt increments.
  - On the BYTES_PER_WORD-th byte, the completed word (including that byte) is pushed to the FIFO in the same cycle, and cnt returns to 0.
  - req_val=0 leaves cnt and the assembly register unchanged.
- Latency: the last byte sampled at edge N gives out_val=1 after edge N when the FIFO was empty (one cycle). No fall-through beyond that.
- FIFO:
  - Push and pop are both allowed in the same cycle.
  - Pop occurs when out_val & out_rdy.
  - fifo_level = pushes − pops, saturating at FIFO_DEPTH.
  - out_dat/out_nbytes hold the head entry while out_val=1 and are stable until popped.
  - When empty, out_val=0 and out_dat/out_nbytes retain their last value.
- Full boundary:
  - A push while full with no pop in the same cycle is dropped: ovfl←1, the FIFO is unchanged, and assembly restarts at cnt=0.
  - A push while full with a pop in the same cycle succeeds; the level stays at FIFO_DEPTH.
- ovfl:
  - Set has priority over ovfl_clr in the same cycle.
  - Otherwise ovfl_clr=1 clears ovfl on the next edge.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- out_nbytes is BYTES_PER_WORD for every full word.
- No X propagation: out_dat never presents uninitialised storage; all RAM entries are reset to 0.

Optional Feature:
- Macro: EXAMPIF_PACK_FLUSH_EN.
- When defined, partial words are flushed after an idle period:
  - The flush timer counts consecutive cycles with req_val=0 while cnt>0.
  - When the timer reaches FLUSH_CYCLES, the partial word is pushed with unused lanes forced to 0 and out_nbytes=cnt. cnt and the timer then return to 0.
  - req_val=1 on the expiry cycle appends the byte, resets the timer and suppresses the flush.
  - A flush into a full FIFO follows the normal drop/ovfl rule.
  - The timer is held at 0 while cnt=0.
- When not defined:
  - No timer logic is present.
  - Partial words wait indefinitely.
  - out_nbytes is constant BYTES_PER_WORD.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, out_rdy=1 -> one cycle after 0x44: out_val=1, out_dat=0x44332211, out_nbytes=4; popped the next edge; fifo_level returns to 0.
- Bytes sent with gaps (req_val toggling 1,0,1,0...) giving 0xA1..0xA4 -> out_dat=0x A4A3A2A1, timing set by the last byte only.
- out_rdy=0, 9 full words pushed (DEPTH=8) -> fifo_level=8, ovfl=1, the 9th word is absent. Then drain with out_rdy=1 -> 8 words in order. Then ovfl_clr=1 -> ovfl=0.
- FIFO full with out_rdy=1 on the same cycle a word completes -> no ovfl; fifo_level stays at 8; the new word appears last in the drain order.
- Assert rst_n low after 2 bytes (0x55,0x66) -> all outputs 0. Then send 0x01..0x04 -> out_dat=0x04030201 (no stale lanes).
- EXAMPIF_PACK_FLUSH_EN defined: bytes 0x77,0x88 then idle for 16 cycles -> push with out_dat=0x00008877, out_nbytes=2. A variant with a byte on cycle 16 -> no flush; cnt=3.
